hilo_pipe: RTL

- Receiving end of the EX-stage HI/LO write interface (hi/lo/whilo from EX).
- Carries HI/LO writes through the EX/MEM and MEM/WB pipeline registers and commits them to the architectural HI/LO register at WB.
- Returns the committed values plus the MEM- and WB-stage pending writes to EX for HI/LO hazard forwarding.
- Single clock domain; sits beside the ex_mem/mem_wb registers in the OpenMIPS core.

---
 rtl/hilo_pipe_pkg.sv | 37 +++
 rtl/hilo_pipe_stage.sv | 48 ++++
 rtl/hilo_pipe.sv | 89 ++++++++
 3 files changed

// File: rtl/hilo_pipe_pkg.sv
// Shared constants and the stage-update decision for the HI/LO write pipeline.
package hilo_pipe_pkg;

  localparam int   REG_BUS_W     = 32;
  localparam int   STALL_BUS_W   = 3;
  localparam int   STALL_EX      = 0;
  localparam int   STALL_MEM     = 1;
  localparam int   STALL_WB      = 2;
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    STAGE_HOLD    = 2'd0,
    STAGE_CLEAR   = 2'd1,
    STAGE_CAPTURE = 2'd2
  } stage_op_e;

  // Clear wins over everything; a stalled producer feeding a running consumer
  // must insert a bubble so the held write is not passed on twice.
  function automatic stage_op_e stage_op(input logic rst,
                                         input logic flush,
                                         input logic stall_up,
                                         input logic stall_down);
    stage_op_e op;
    if (rst == RST_ENABLE || flush)
      op = STAGE_CLEAR;
    else if (stall_up && !stall_down)
      op = STAGE_CLEAR;
    else if (!stall_up)
      op = STAGE_CAPTURE;
    else
      op = STAGE_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/hilo_pipe_stage.sv
// One HI/LO pipeline register (EX/MEM or MEM/WB) with clear/bubble/capture/hold.
module hilo_pipe_stage
  import hilo_pipe_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_up_i,
  input  logic              stall_down_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              whilo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o
);

  logic [DATA_W-1:0] hi_q, lo_q;
  logic              whilo_q;
  stage_op_e         op_d;

  always_comb begin
    op_d = stage_op(rst, flush_i, stall_up_i, stall_down_i);
  end

  always_ff @(posedge clk) begin
    case (op_d)
      STAGE_CLEAR: begin
        whilo_q <= WRITE_DISABLE;
        hi_q    <= '0;
        lo_q    <= '0;
      end
      STAGE_CAPTURE: begin
        whilo_q <= whilo_i;
        hi_q    <= hi_i;
        lo_q    <= lo_i;
      end
      default: ;
    endcase
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign whilo_o = whilo_q;

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline EX->MEM->WB with architectural HI/LO commit at WB.
// Optional macro HILO_BYPASS_EN adds the forwarding mux outputs fwd_hi_o/fwd_lo_o.
module hilo_pipe
  import hilo_pipe_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      ex_hi_i,
  input  logic [DATA_W-1:0]      ex_lo_i,
  input  logic                   ex_whilo_i,
  input  logic [STALL_BUS_W-1:0] stall,
  input  logic                   flush,
  output logic [DATA_W-1:0]      mem_hi_o,
  output logic [DATA_W-1:0]      mem_lo_o,
  output logic                   mem_whilo_o,
  output logic [DATA_W-1:0]      wb_hi_o,
  output logic [DATA_W-1:0]      wb_lo_o,
  output logic                   wb_whilo_o,
  output logic [DATA_W-1:0]      hi_o,
  output logic [DATA_W-1:0]      lo_o
`ifdef HILO_BYPASS_EN
  ,
  output logic [DATA_W-1:0]      fwd_hi_o,
  output logic [DATA_W-1:0]      fwd_lo_o
`endif
);

  logic [DATA_W-1:0] hi_q, lo_q;

  hilo_pipe_stage #(.DATA_W(DATA_W)) u_ex_mem (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .stall_up_i   (stall[STALL_EX]),
    .stall_down_i (stall[STALL_MEM]),
    .hi_i         (ex_hi_i),
    .lo_i         (ex_lo_i),
    .whilo_i      (ex_whilo_i),
    .hi_o         (mem_hi_o),
    .lo_o         (mem_lo_o),
    .whilo_o      (mem_whilo_o)
  );

  hilo_pipe_stage #(.DATA_W(DATA_W)) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .stall_up_i   (stall[STALL_MEM]),
    .stall_down_i (stall[STALL_WB]),
    .hi_i         (mem_hi_o),
    .lo_i         (mem_lo_o),
    .whilo_i      (mem_whilo_o),
    .hi_o         (wb_hi_o),
    .lo_o         (wb_lo_o),
    .whilo_o      (wb_whilo_o)
  );

  // Architectural value survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo_o == WRITE_ENABLE && !stall[STALL_WB]) begin
      hi_q <= wb_hi_o;
      lo_q <= wb_lo_o;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

`ifdef HILO_BYPASS_EN
  // Youngest pending write wins.
  always_comb begin
    fwd_hi_o = hi_q;
    fwd_lo_o = lo_q;
    if (mem_whilo_o) begin
      fwd_hi_o = mem_hi_o;
      fwd_lo_o = mem_lo_o;
    end else if (wb_whilo_o) begin
      fwd_hi_o = wb_hi_o;
      fwd_lo_o = wb_lo_o;
    end
  end
`endif

endmodule
